// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// single-entry registered response buffer and valid/ready handshake per port.
module alu_share_arbiter #(
    parameter  int unsigned W     = 32,
    localparam int unsigned CTR_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_freeze,

    input  logic             i_req0_valid,
    output logic             o_req0_ready_c,
    input  logic [W-1:0]     i_req0_a,
    input  logic [W-1:0]     i_req0_b,
    input  logic [CTR_W-1:0] i_req0_ctr,
    output logic             o_rsp0_valid,
    input  logic             i_rsp0_ready,
    output logic [W-1:0]     o_rsp0_result,
    output logic             o_rsp0_less,
    output logic             o_rsp0_zero,

    input  logic             i_req1_valid,
    output logic             o_req1_ready_c,
    input  logic [W-1:0]     i_req1_a,
    input  logic [W-1:0]     i_req1_b,
    input  logic [CTR_W-1:0] i_req1_ctr,
    output logic             o_rsp1_valid,
    input  logic             i_rsp1_ready,
    output logic [W-1:0]     o_rsp1_result,
    output logic             o_rsp1_less,
    output logic             o_rsp1_zero,

    output logic [W-1:0]     o_alu_dataa_c,
    output logic [W-1:0]     o_alu_datab_c,
    output logic [CTR_W-1:0] o_alu_ctr_c,
    input  logic [W-1:0]     i_alu_result,
    input  logic             i_alu_less,
    input  logic             i_alu_zero
);

    logic             r_rsp0_valid;
    logic [W-1:0]     r_rsp0_result;
    logic             r_rsp0_less;
    logic             r_rsp0_zero;
    logic             r_rsp1_valid;
    logic [W-1:0]     r_rsp1_result;
    logic             r_rsp1_less;
    logic             r_rsp1_zero;
    logic             r_last_grant;

    logic             w_free0;
    logic             w_free1;
    logic             w_elig0;
    logic             w_elig1;
    logic             w_gnt0;
    logic             w_gnt1;

    // A full buffer is still free when its consumer drains it this cycle.
    assign w_free0 = ~r_rsp0_valid | i_rsp0_ready;
    assign w_free1 = ~r_rsp1_valid | i_rsp1_ready;
    assign w_elig0 = i_req0_valid & ~i_freeze & ~i_rst & w_free0;
    assign w_elig1 = i_req1_valid & ~i_freeze & ~i_rst & w_free1;

    // On a tie the port that did not win last time gets the ALU.
    assign w_gnt0 = w_elig0 & (~w_elig1 | r_last_grant);
    assign w_gnt1 = w_elig1 & (~w_elig0 | ~r_last_grant);

    assign o_req0_ready_c = w_gnt0;
    assign o_req1_ready_c = w_gnt1;

    always_comb begin
        o_alu_dataa_c = '0;
        o_alu_datab_c = '0;
        o_alu_ctr_c   = '0;
        if (w_gnt0) begin
            o_alu_dataa_c = i_req0_a;
            o_alu_datab_c = i_req0_b;
            o_alu_ctr_c   = i_req0_ctr;
        end else if (w_gnt1) begin
            o_alu_dataa_c = i_req1_a;
            o_alu_datab_c = i_req1_b;
            o_alu_ctr_c   = i_req1_ctr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp0_valid  <= 1'b0;
            r_rsp0_result <= '0;
            r_rsp0_less   <= 1'b0;
            r_rsp0_zero   <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_rsp1_result <= '0;
            r_rsp1_less   <= 1'b0;
            r_rsp1_zero   <= 1'b0;
            r_last_grant  <= 1'b1;
        end else begin
            // A new grant refills the buffer even if it drains this cycle.
            if (w_gnt0) begin
                r_rsp0_valid  <= 1'b1;
                r_rsp0_result <= i_alu_result;
                r_rsp0_less   <= i_alu_less;
                r_rsp0_zero   <= i_alu_zero;
            end else if (i_rsp0_ready) begin
                r_rsp0_valid  <= 1'b0;
            end

            if (w_gnt1) begin
                r_rsp1_valid  <= 1'b1;
                r_rsp1_result <= i_alu_result;
                r_rsp1_less   <= i_alu_less;
                r_rsp1_zero   <= i_alu_zero;
            end else if (i_rsp1_ready) begin
                r_rsp1_valid  <= 1'b0;
            end

            if (w_gnt0) begin
                r_last_grant <= 1'b0;
            end else if (w_gnt1) begin
                r_last_grant <= 1'b1;
            end
        end
    end

    assign o_rsp0_valid  = r_rsp0_valid;
    assign o_rsp0_result = r_rsp0_result;
    assign o_rsp0_less   = r_rsp0_less;
    assign o_rsp0_zero   = r_rsp0_zero;
    assign o_rsp1_valid  = r_rsp1_valid;
    assign o_rsp1_result = r_rsp1_result;
    assign o_rsp1_less   = r_rsp1_less;
    assign o_rsp1_zero   = r_rsp1_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a vector table for the main stream,
// then hand sequences for mid-stream reset and control-code pass-through.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [3:0]  req0_ctr;
    logic        rsp0_valid, rsp0_ready, rsp0_less, rsp0_zero;
    logic [31:0] rsp0_result;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [3:0]  req1_ctr;
    logic        rsp1_valid, rsp1_ready, rsp1_less, rsp1_zero;
    logic [31:0] rsp1_result;
    logic [31:0] alu_dataa, alu_datab, alu_result;
    logic [3:0]  alu_ctr;
    logic        alu_less, alu_zero;

    int checks = 0;
    int errors = 0;
    int step   = 0;

    alu_share_arbiter #(.W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_freeze(freeze),
        .i_req0_valid(req0_valid), .o_req0_ready_c(req0_ready),
        .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_ctr(req0_ctr),
        .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready),
        .o_rsp0_result(rsp0_result), .o_rsp0_less(rsp0_less), .o_rsp0_zero(rsp0_zero),
        .i_req1_valid(req1_valid), .o_req1_ready_c(req1_ready),
        .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_ctr(req1_ctr),
        .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready),
        .o_rsp1_result(rsp1_result), .o_rsp1_less(rsp1_less), .o_rsp1_zero(rsp1_zero),
        .o_alu_dataa_c(alu_dataa), .o_alu_datab_c(alu_datab), .o_alu_ctr_c(alu_ctr),
        .i_alu_result(alu_result), .i_alu_less(alu_less), .i_alu_zero(alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: add, sub, slt; other codes xor. less is the signed compare.
    always_comb begin
        case (alu_ctr)
            4'b0000: alu_result = alu_dataa + alu_datab;
            4'b1000: alu_result = alu_dataa - alu_datab;
            4'b0010: alu_result = 32'($signed(alu_dataa) < $signed(alu_datab));
            default: alu_result = alu_dataa ^ alu_datab;
        endcase
        alu_less = $signed(alu_dataa) < $signed(alu_datab);
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct {
        logic        frz;
        logic        v0;
        logic [31:0] a0, b0;
        logic [3:0]  c0;
        logic        v1;
        logic [31:0] a1, b1;
        logic [3:0]  c1;
        logic        r0, r1;
        logic        g0, g1;
        logic [31:0] xa, xb;
        logic [3:0]  xc;
        logic        rv0;
        logic [31:0] res0;
        logic        l0, z0;
        logic        rv1;
        logic [31:0] res1;
        logic        l1, z1;
    } vec_t;

    localparam int unsigned NV = 20;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic drive(input logic frz, input logic v0, input logic [31:0] a0,
                         input logic [31:0] b0, input logic [3:0] c0, input logic v1,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                         input logic r0, input logic r1);
        freeze = frz;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctr = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctr = c1;
        rsp0_ready = r0; rsp1_ready = r1;
    endtask

    initial begin
        // frz v0 a0 b0 c0 | v1 a1 b1 c1 | r0 r1 || g0 g1 xa xb xc || rv0 res0 l0 z0 || rv1 res1 l1 z1
        vecs[0]  = '{0,1,5,3,0, 0,0,0,0, 1,1, 1,0,5,3,0, 0,0,0,0, 0,0,0,0};
        vecs[1]  = '{0,0,0,0,0, 0,0,0,0, 1,1, 0,0,0,0,0, 1,8,0,0, 0,0,0,0};
        vecs[2]  = '{0,0,0,0,0, 0,0,0,0, 1,1, 0,0,0,0,0, 0,8,0,0, 0,0,0,0};
        vecs[3]  = '{0,0,0,0,0, 1,1,2,2, 1,1, 0,1,1,2,2, 0,8,0,0, 0,0,0,0};
        vecs[4]  = '{0,1,7,7,8, 1,1,2,2, 1,1, 1,0,7,7,8, 0,8,0,0, 1,1,1,0};
        vecs[5]  = '{0,1,7,7,8, 1,1,2,2, 1,1, 0,1,1,2,2, 1,0,0,1, 0,1,1,0};
        vecs[6]  = '{0,1,7,7,8, 1,1,2,2, 1,1, 1,0,7,7,8, 0,0,0,1, 1,1,1,0};
        vecs[7]  = '{0,1,7,7,8, 1,1,2,2, 1,1, 0,1,1,2,2, 1,0,0,1, 0,1,1,0};
        vecs[8]  = '{0,1,5,3,0, 1,1,2,2, 0,1, 1,0,5,3,0, 0,0,0,1, 1,1,1,0};
        vecs[9]  = '{0,1,6,3,0, 1,1,2,2, 0,1, 0,1,1,2,2, 1,8,0,0, 0,1,1,0};
        vecs[10] = '{0,1,6,3,0, 1,1,2,2, 0,1, 0,1,1,2,2, 1,8,0,0, 1,1,1,0};
        vecs[11] = '{0,1,6,3,0, 1,1,2,2, 1,1, 1,0,6,3,0, 1,8,0,0, 1,1,1,0};
        vecs[12] = '{1,1,6,3,0, 1,1,2,2, 1,1, 0,0,0,0,0, 1,9,0,0, 0,1,1,0};
        vecs[13] = '{1,1,6,3,0, 1,1,2,2, 1,1, 0,0,0,0,0, 0,9,0,0, 0,1,1,0};
        vecs[14] = '{0,0,0,0,0, 1,32'hFFFF_FFFF,1,0, 1,1, 0,1,32'hFFFF_FFFF,1,0, 0,9,0,0, 0,1,1,0};
        vecs[15] = '{0,0,0,0,0, 1,32'hFFFF_FFFF,1,0, 1,1, 0,1,32'hFFFF_FFFF,1,0, 0,9,0,0, 1,0,1,1};
        vecs[16] = '{0,0,0,0,0, 1,32'hFFFF_FFFF,1,0, 1,1, 0,1,32'hFFFF_FFFF,1,0, 0,9,0,0, 1,0,1,1};
        vecs[17] = '{0,0,0,0,0, 1,32'hFFFF_FFFF,1,0, 1,1, 0,1,32'hFFFF_FFFF,1,0, 0,9,0,0, 1,0,1,1};
        vecs[18] = '{0,0,0,0,0, 0,0,0,0, 1,1, 0,0,0,0,0, 0,9,0,0, 1,0,1,1};
        vecs[19] = '{0,0,0,0,0, 0,0,0,0, 1,1, 0,0,0,0,0, 0,9,0,0, 0,0,1,1};

        rst = 1'b1;
        drive(0, 0,0,0,0, 0,0,0,0, 0,0);
        @(negedge clk);
        drive(0, 1,5,3,0, 1,1,2,2, 1,1);
        #2;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("rst_rsp0_result", rsp0_result, 32'd0);
        chk("rst_alu_ctr", 32'(alu_ctr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < int'(NV); i++) begin
            step = i;
            drive(vecs[i].frz, vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].c0,
                  vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].c1, vecs[i].r0, vecs[i].r1);
            #2;
            chk("ready0", 32'(req0_ready), 32'(vecs[i].g0));
            chk("ready1", 32'(req1_ready), 32'(vecs[i].g1));
            chk("alu_dataa", alu_dataa, vecs[i].xa);
            chk("alu_datab", alu_datab, vecs[i].xb);
            chk("alu_ctr", 32'(alu_ctr), 32'(vecs[i].xc));
            chk("rsp0_valid", 32'(rsp0_valid), 32'(vecs[i].rv0));
            chk("rsp0_result", rsp0_result, vecs[i].res0);
            chk("rsp0_less", 32'(rsp0_less), 32'(vecs[i].l0));
            chk("rsp0_zero", 32'(rsp0_zero), 32'(vecs[i].z0));
            chk("rsp1_valid", 32'(rsp1_valid), 32'(vecs[i].rv1));
            chk("rsp1_result", rsp1_result, vecs[i].res1);
            chk("rsp1_less", 32'(rsp1_less), 32'(vecs[i].l1));
            chk("rsp1_zero", 32'(rsp1_zero), 32'(vecs[i].z1));
            @(negedge clk);
        end

        // Reset while port 0 holds a response and port 1 is being served.
        step = 100;
        drive(0, 1,5,3,0, 0,0,0,0, 0,1);
        #2;
        chk("mr_grant0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        step = 101;
        drive(0, 1,5,3,0, 1,1,2,2, 0,0);
        #2;
        chk("mr_ready0_blocked", 32'(req0_ready), 32'd0);
        chk("mr_grant1", 32'(req1_ready), 32'd1);
        chk("mr_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("mr_rsp0_result", rsp0_result, 32'd8);
        @(negedge clk);
        step = 102;
        rst = 1'b1;
        #2;
        chk("mr_rst_ready0", 32'(req0_ready), 32'd0);
        chk("mr_rst_ready1", 32'(req1_ready), 32'd0);
        chk("mr_rsp1_valid_pre", 32'(rsp1_valid), 32'd1);
        @(negedge clk);
        step = 103;
        rst = 1'b0;
        drive(0, 1,5,3,0, 1,1,2,2, 1,1);
        #2;
        chk("mr_rsp0_cleared", 32'(rsp0_valid), 32'd0);
        chk("mr_rsp1_cleared", 32'(rsp1_valid), 32'd0);
        chk("mr_rsp0_result0", rsp0_result, 32'd0);
        chk("mr_rsp1_result0", rsp1_result, 32'd0);
        chk("mr_tie_ready0", 32'(req0_ready), 32'd1);
        chk("mr_tie_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);

        // Every control code reaches the ALU untouched; port 0 alone is granted each cycle.
        for (int k = 0; k < 16; k++) begin
            step = 200 + k;
            drive(0, 1, 32'(k) + 32'h100, 32'h55, 4'(k), 0,0,0,0, 1,1);
            #2;
            chk("sweep_ready0", 32'(req0_ready), 32'd1);
            chk("sweep_ctr", 32'(alu_ctr), 32'(k));
            chk("sweep_dataa", alu_dataa, 32'(k) + 32'h100);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
